// File: rtl/excess3_pkg.sv
// Shared Excess-3 definitions for the BCD <-> Excess-3 encoder/decoder pair.
// Contents: code offset and legal code bounds, decoder FSM state type,
// nibble width, and a legality helper.
package excess3_pkg;

  localparam int unsigned NIBBLE_W = 4;

  // Excess-3 code = BCD + 3; legal codes therefore span 3..12.
  localparam logic [NIBBLE_W-1:0] EX3_OFFSET = 4'd3;
  localparam logic [NIBBLE_W-1:0] EX3_MIN    = 4'd3;
  localparam logic [NIBBLE_W-1:0] EX3_MAX    = 4'd12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } ex3_dec_state_t;

  // True when the nibble is a valid Excess-3 code.
  function automatic logic ex3_is_legal(input logic [NIBBLE_W-1:0] code);
    return (code >= EX3_MIN) && (code <= EX3_MAX);
  endfunction

endpackage

// File: rtl/excess3_to_bcd_decoder_if.sv
// Word-level handshake bundle between an Excess-3 source, the decoder and
// the BCD consumer.
//   in_valid/in_ready/in_data    : source -> decoder word transfer
//   out_valid/out_ready          : decoder -> consumer result transfer
//   out_data/err_mask            : decoded BCD word and per-digit error flags
//   busy                         : decoder is stepping through digits
// master = source/consumer side, slave = decoder side.
interface excess3_to_bcd_decoder_if #(
  parameter int unsigned DIGITS = 4
);

  localparam int unsigned DATA_W = 4 * DIGITS;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DIGITS-1:0] err_mask;
  logic              busy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  err_mask,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output err_mask,
    output busy
  );

endinterface

// File: rtl/excess3_digit_dec.sv
// Single-nibble Excess-3 -> BCD decoder (purely combinational).
//   code : Excess-3 nibble
//   bcd  : decoded BCD digit, forced to 0 for illegal codes
//   err  : 1 when code is outside 3..12
module excess3_digit_dec
  import excess3_pkg::*;
(
  input  logic [NIBBLE_W-1:0] code,
  output logic [NIBBLE_W-1:0] bcd,
  output logic                err
);

  logic legal;

  assign legal = ex3_is_legal(code);
  assign err   = ~legal;

  // Subtraction is 4-bit modular; illegal codes are masked to zero.
  assign bcd   = legal ? NIBBLE_W'(code - EX3_OFFSET) : '0;

endmodule

// File: rtl/excess3_to_bcd_decoder.sv
// Multi-digit Excess-3 -> BCD decoder. Accepts a packed word of DIGITS
// Excess-3 nibbles, decodes one nibble per clock through a single digit
// decoder, and holds the completed BCD word plus per-digit error mask until
// the consumer takes it.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high (wins over everything)
//   enb  : block enable; low aborts any word in flight and clears outputs
//   bus  : slave side of excess3_to_bcd_decoder_if (handshakes, data, busy)
// All bus outputs are registered.
module excess3_to_bcd_decoder
  import excess3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  excess3_to_bcd_decoder_if.slave  bus
);

  localparam int unsigned DATA_W = NIBBLE_W * DIGITS;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // State and datapath registers
  ex3_dec_state_t      state_q,     state_d;
  logic [DATA_W-1:0]   word_q,      word_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [DATA_W-1:0]   res_data_q,  res_data_d;
  logic [DIGITS-1:0]   res_err_q,   res_err_d;

  // Registered outputs
  logic                in_ready_q,  in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic [DIGITS-1:0]   err_mask_q,  err_mask_d;
  logic                busy_q,      busy_d;

  // Current digit selected by the index, and its decode
  logic [NIBBLE_W-1:0] cur_code;
  logic [NIBBLE_W-1:0] cur_bcd;
  logic                cur_err;

  assign cur_code = word_q[32'(idx_q) * NIBBLE_W +: NIBBLE_W];

  excess3_digit_dec u_digit_dec (
    .code (cur_code),
    .bcd  (cur_bcd),
    .err  (cur_err)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      res_data_q  <= '0;
      res_err_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_mask_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_mask_q  <= err_mask_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_mask_d  = err_mask_q;
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;

    if (!enb) begin
      // Abort: discard the word in flight and clear everything visible.
      state_d     = IDLE;
      word_d      = '0;
      idx_d       = '0;
      res_data_d  = '0;
      res_err_d   = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      err_mask_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            word_d     = bus.in_data;
            idx_d      = '0;
            res_data_d = '0;
            res_err_d  = '0;
            state_d    = DECODE;
          end
        end

        DECODE: begin
          res_data_d[32'(idx_q) * NIBBLE_W +: NIBBLE_W] = cur_bcd;
          res_err_d[idx_q]                              = cur_err;
          if (idx_q == IDX_LAST) begin
            // Publish the full word only once its last digit is in.
            out_data_d  = res_data_d;
            err_mask_d  = res_err_d;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase

      // Registered flags follow the state being entered.
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d == DECODE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err_mask  = err_mask_q;
  assign bus.busy      = busy_q;

endmodule
